bus_memory_ctrl: RTL and testbench

//  Shared-bus responder and main memory for the snooping MSI cache system.
//  - Receives miss/invalidate messages that CPUs drive on their 13-bit bus_out.
//  - Arbitrates between CPUs and rebroadcasts each message to the other CPUs.
//  - Collects their write-back/abort replies and answers read misses with data

---
 rtl/bus_pkg.sv | 42 ++++
 rtl/rr_arbiter.sv | 31 +++
 rtl/bus_memory_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_bus_memory_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Bus word layout and controller encodings for the snooping MSI bus.
// The cpu model uses the same package.
package bus_pkg;

  localparam int BUS_W     = 13;
  localparam int BUS_WB    = 12;
  localparam int BUS_ABORT = 11;
  localparam int BUS_REQ   = 10;
  localparam int BUS_RM    = 9;
  localparam int BUS_WM    = 8;
  localparam int BUS_INV   = 7;

  localparam int ADDR_HI   = 6;
  localparam int ADDR_LO   = 4;
  localparam int DATA_HI   = 3;
  localparam int DATA_LO   = 0;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 4;
  localparam int MEM_DEPTH = 8;

  typedef enum logic [1:0] {MSG_NONE, MSG_RM, MSG_WM, MSG_INV} msg_t;

  typedef enum logic [2:0] {ST_IDLE, ST_BCAST, ST_SNOOP, ST_MEMRD, ST_RESP} state_t;

  // Input is bus bits [9:7]; read miss outranks write miss outranks invalidate.
  function automatic msg_t msg_decode(input logic [2:0] type_bits);
    if (type_bits[2]) return MSG_RM;
    if (type_bits[1]) return MSG_WM;
    if (type_bits[0]) return MSG_INV;
    return MSG_NONE;
  endfunction

  function automatic logic [2:0] msg_bits(input msg_t m);
    case (m)
      MSG_RM:  return 3'b100;
      MSG_WM:  return 3'b010;
      MSG_INV: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
// The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           any
);

  int idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_memory_ctrl.sv
// Shared-bus responder and 8x4 main memory for the snooping MSI caches.
// Defining BUS_MEM_STATS_EN adds saturating per-type transaction counters.
//
// state    | meaning
// IDLE     | arbitrate; latch requester, address and type
// BCAST    | rebroadcast the message to every other CPU
// SNOOP    | collect write-back/abort replies for SNOOP_CYCLES cycles
// MEMRD    | memory read latency for a read miss with no owner
// RESP     | data-valid word to the requester, then retire
module bus_memory_ctrl
  import bus_pkg::*;
#(
  parameter int NCPU         = 3,
  parameter int SNOOP_CYCLES = 2,
  parameter int MEM_LAT      = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NCPU*BUS_W-1:0] bus_from_cpu,
  output logic [NCPU*BUS_W-1:0] bus_to_cpu,
  output logic                  busy
`ifdef BUS_MEM_STATS_EN
  ,
  output logic [15:0]           stat_rd,
  output logic [15:0]           stat_wr,
  output logic [15:0]           stat_inv,
  output logic [15:0]           stat_wb
`endif
);

  localparam int IDW   = (NCPU > 1) ? $clog2(NCPU) : 1;
  localparam int CNT_W = 16;

  state_t            state_q, state_d;
  msg_t              type_q, type_d;
  logic [IDW-1:0]    g_q, g_d, rr_q, rr_d, arb_id, retire_id;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d, snoop_data;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              captured_q, captured_d, busy_q, busy_d;
  logic [NCPU-1:0]   served_q, served_d, req_vec, elig, arb_grant;
  logic              arb_any, retire, snoop_hit;
  logic [BUS_W-1:0]  from_w [NCPU];
  logic [BUS_W-1:0]  to_q [NCPU];
  logic [BUS_W-1:0]  to_d [NCPU];
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] mem_d [MEM_DEPTH];

  for (genvar i = 0; i < NCPU; i++) begin : g_port
    assign from_w[i]                      = bus_from_cpu[i*BUS_W +: BUS_W];
    assign req_vec[i]                     = from_w[i][BUS_REQ];
    assign bus_to_cpu[i*BUS_W +: BUS_W]   = to_q[i];
  end

  assign elig = req_vec & ~served_q;
  assign busy = busy_q;

  rr_arbiter #(.N(NCPU)) u_arb (
    .req      (elig),
    .ptr      (rr_q),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .any      (arb_any)
  );

  function automatic logic [BUS_W-1:0] bcast_word(input msg_t m, input logic [ADDR_W-1:0] a);
    return {3'b000, msg_bits(m), a, 4'h0};
  endfunction

  function automatic logic [BUS_W-1:0] resp_word(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] d);
    return {3'b001, 3'b000, a, d};
  endfunction

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    g_d        = g_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    captured_d = captured_q;
    busy_d     = busy_q;
    rr_d       = rr_q;
    mem_d      = mem_q;
    // A requester that drops bit 10 becomes eligible again.
    served_d   = served_q & req_vec;
    retire     = 1'b0;
    retire_id  = g_q;
    snoop_hit  = 1'b0;
    snoop_data = '0;
    for (int i = 0; i < NCPU; i++) to_d[i] = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          g_d        = arb_id;
          addr_d     = from_w[arb_id][ADDR_HI:ADDR_LO];
          type_d     = msg_decode(from_w[arb_id][BUS_RM:BUS_INV]);
          captured_d = 1'b0;
          if (type_d == MSG_NONE) begin
            retire    = 1'b1;
            retire_id = arb_id;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_BCAST;
            for (int j = 0; j < NCPU; j++)
              if (!arb_grant[j]) to_d[j] = bcast_word(type_d, addr_d);
          end
        end
      end
      ST_BCAST: begin
        state_d = ST_SNOOP;
        cnt_d   = CNT_W'(SNOOP_CYCLES - 1);
      end
      ST_SNOOP: begin
        if (!captured_q) begin
          for (int j = 0; j < NCPU; j++) begin
            if (!snoop_hit && IDW'(j) != g_q &&
                (from_w[j][BUS_WB] || from_w[j][BUS_ABORT]) &&
                from_w[j][ADDR_HI:ADDR_LO] == addr_q) begin
              snoop_hit  = 1'b1;
              snoop_data = from_w[j][DATA_HI:DATA_LO];
            end
          end
        end
        if (snoop_hit) begin
          captured_d    = 1'b1;
          data_d        = snoop_data;
          mem_d[addr_q] = snoop_data;
        end
        if (cnt_q == '0) begin
          if (type_q != MSG_RM) begin
            retire = 1'b1;
          end else if (captured_d) begin
            state_d  = ST_RESP;
            to_d[g_q] = resp_word(addr_q, data_d);
          end else begin
            state_d = ST_MEMRD;
            cnt_d   = CNT_W'(MEM_LAT - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_MEMRD: begin
        if (cnt_q == '0) begin
          state_d   = ST_RESP;
          data_d    = mem_q[addr_q];
          to_d[g_q] = resp_word(addr_q, mem_q[addr_q]);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: retire = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    if (retire) begin
      served_d[retire_id] = 1'b1;
      rr_d    = (retire_id == IDW'(NCPU - 1)) ? '0 : retire_id + IDW'(1);
      busy_d  = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      type_q     <= MSG_NONE;
      g_q        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      captured_q <= 1'b0;
      busy_q     <= 1'b0;
      rr_q       <= '0;
      served_q   <= '0;
      for (int i = 0; i < NCPU; i++) to_q[i] <= '0;
      for (int a = 0; a < MEM_DEPTH; a++) mem_q[a] <= DATA_W'(a);
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      g_q        <= g_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      busy_q     <= busy_d;
      rr_q       <= rr_d;
      served_q   <= served_d;
      for (int i = 0; i < NCPU; i++) to_q[i] <= to_d[i];
      for (int a = 0; a < MEM_DEPTH; a++) mem_q[a] <= mem_d[a];
    end
  end

`ifdef BUS_MEM_STATS_EN
  logic [15:0] st_rd_q, st_rd_d, st_wr_q, st_wr_d, st_inv_q, st_inv_d, st_wb_q, st_wb_d;
  msg_t        retire_type;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  // A retire from IDLE is a request with no type bits and is not counted.
  assign retire_type = (state_q == ST_IDLE) ? MSG_NONE : type_q;

  always_comb begin
    st_rd_d  = sat_inc(st_rd_q,  retire && retire_type == MSG_RM);
    st_wr_d  = sat_inc(st_wr_q,  retire && retire_type == MSG_WM);
    st_inv_d = sat_inc(st_inv_q, retire && retire_type == MSG_INV);
    st_wb_d  = sat_inc(st_wb_q,  snoop_hit);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_rd_q  <= '0;
      st_wr_q  <= '0;
      st_inv_q <= '0;
      st_wb_q  <= '0;
    end else begin
      st_rd_q  <= st_rd_d;
      st_wr_q  <= st_wr_d;
      st_inv_q <= st_inv_d;
      st_wb_q  <= st_wb_d;
    end
  end

  assign stat_rd  = st_rd_q;
  assign stat_wr  = st_wr_q;
  assign stat_inv = st_inv_q;
  assign stat_wb  = st_wb_q;
`endif

endmodule

// File: tb/tb_bus_memory_ctrl.sv
// Self-checking bench for bus_memory_ctrl: directed scenarios plus random
// transactions against a transaction-level memory/snoop reference model.
module tb_bus_memory_ctrl;
  import bus_pkg::*;

  localparam int NCPU = 3;
  localparam int SC   = 2;
  localparam int ML   = 2;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NCPU*BUS_W-1:0] bus_from_cpu;
  logic [NCPU*BUS_W-1:0] bus_to_cpu;
  logic                  busy;
`ifdef BUS_MEM_STATS_EN
  logic [15:0] stat_rd, stat_wr, stat_inv, stat_wb;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [12:0] from_w [NCPU];
  logic [3:0]  mem_m [8];
  int          rr_m;
  logic        rep_on [NCPU];
  logic [12:0] rep_w [NCPU];
  int          rep_cyc [NCPU];

  always #5 clock = ~clock;

  for (genvar i = 0; i < NCPU; i++) begin : g_drv
    assign bus_from_cpu[i*13 +: 13] = from_w[i];
  end

  bus_memory_ctrl #(.NCPU(NCPU), .SNOOP_CYCLES(SC), .MEM_LAT(ML)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus_from_cpu (bus_from_cpu),
    .bus_to_cpu   (bus_to_cpu),
    .busy         (busy)
`ifdef BUS_MEM_STATS_EN
    ,
    .stat_rd      (stat_rd),
    .stat_wr      (stat_wr),
    .stat_inv     (stat_inv),
    .stat_wb      (stat_wb)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] to_w(input int i);
    return bus_to_cpu[i*13 +: 13];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int a = 0; a < 8; a++) mem_m[a] = 4'(a);
    rr_m = 0;
  endtask

  task automatic clear_reps();
    for (int j = 0; j < NCPU; j++) begin
      rep_on[j] = 1'b0;
      rep_w[j] = '0;
      rep_cyc[j] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    for (int j = 0; j < NCPU; j++) from_w[j] = '0;
    clear_reps();
    model_reset();
    #1;
    check("rst_busy", busy, 0);
    for (int j = 0; j < NCPU; j++) check("rst_bus_to_cpu", to_w(j), 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  // One transaction from a single requester; repliers come from rep_* arrays.
  task automatic do_txn(input int cpu, input logic [2:0] tbits, input logic [2:0] addr);
    logic [2:0]  onehot;
    logic        hit;
    logic [3:0]  exp_data;
    logic [12:0] t;
    int          c, exp_lat;
    onehot = tbits[2] ? 3'b100 : tbits[1] ? 3'b010 : tbits[0] ? 3'b001 : 3'b000;
    hit = 1'b0;
    exp_data = '0;
    if (onehot != 3'b000)
      for (int cy = 2; cy <= 3; cy++)
        for (int j = 0; j < NCPU; j++)
          if (!hit && j != cpu && rep_on[j] && rep_cyc[j] == cy &&
              (rep_w[j][12] || rep_w[j][11]) && rep_w[j][6:4] == addr) begin
            hit = 1'b1;
            mem_m[addr] = rep_w[j][3:0];
          end
    exp_data = mem_m[addr];
    exp_lat = (onehot == 3'b100) ? (hit ? 2 + SC : 2 + SC + ML) : 2 + SC;

    from_w[cpu] = {3'b001, tbits, addr, 4'h0};
    tick();
    c = 1;
    rr_m = (cpu + 1) % NCPU;
    if (onehot == 3'b000) begin
      check("notype_busy", busy, 0);
      for (int j = 0; j < NCPU; j++) check("notype_out", to_w(j), 0);
      from_w[cpu] = '0;
      clear_reps();
      tick();
      return;
    end
    check("grant_busy", busy, 1);
    for (int j = 0; j < NCPU; j++)
      check("bcast", to_w(j), (j == cpu) ? 13'h0 : {3'b000, onehot, addr, 4'h0});
    while (c < 40) begin
      for (int j = 0; j < NCPU; j++)
        if (j != cpu) from_w[j] = (rep_on[j] && rep_cyc[j] == c) ? rep_w[j] : 13'h0;
      tick();
      c++;
      t = to_w(cpu);
      if (onehot == 3'b100 && t[10]) break;
      if (onehot != 3'b100 && !busy) break;
    end
    for (int j = 0; j < NCPU; j++) if (j != cpu) from_w[j] = '0;
    check(onehot == 3'b100 ? "rd_latency" : "retire_latency", c, exp_lat);
    if (onehot == 3'b100) begin
      check("resp_word", to_w(cpu), {3'b001, 3'b000, addr, exp_data});
      for (int j = 0; j < NCPU; j++) if (j != cpu) check("resp_others", to_w(j), 0);
      check("resp_busy", busy, 1);
      tick();
      check("retired_busy", busy, 0);
    end else begin
      for (int j = 0; j < NCPU; j++) check("no_resp", to_w(j), 0);
    end
    from_w[cpu] = '0;
    clear_reps();
    tick();
  endtask

  initial begin
    int          w, o, c, hb, kind;
    logic [12:0] t;
    logic [2:0]  tb3, ad;
    for (int j = 0; j < NCPU; j++) from_w[j] = '0;
    clear_reps();
    model_reset();

    do_reset();

    // CPU1 read miss, no owner: data from reset memory contents
    do_txn(1, 3'b100, 3'd5);

    // CPU2 aborts with data A during SNOOP: owner data and memory update
    rep_on[2] = 1'b1; rep_w[2] = {1'b0, 1'b1, 1'b0, 3'b000, 3'd3, 4'hA}; rep_cyc[2] = 2;
    do_txn(0, 3'b100, 3'd3);
    do_txn(1, 3'b100, 3'd3);

    do_txn(1, 3'b001, 3'd6);
    do_txn(0, 3'b000, 3'd2);
    do_txn(2, 3'b111, 3'd4);
    do_txn(0, 3'b011, 3'd1);

    for (int n = 0; n < 40; n++) begin
      w   = $urandom_range(NCPU - 1, 0);
      tb3 = 3'($urandom_range(7, 1));
      ad  = 3'($urandom_range(7, 0));
      for (int j = 0; j < NCPU; j++) begin
        kind       = $urandom_range(2, 0);
        rep_on[j]  = (j != w) && ($urandom_range(1, 0) == 1);
        rep_w[j]   = {kind == 0, kind != 0, 1'b0, 3'b000,
                      (kind == 2) ? ad + 3'd1 : ad, 4'($urandom_range(15, 0))};
        rep_cyc[j] = $urandom_range(3, 1);
      end
      do_txn(w, tb3, ad);
    end

    // Reset pulsed during MEMRD abandons the transaction and restores memory
    from_w[1] = {3'b001, 3'b100, 3'd3, 4'h0};
    repeat (4) tick();
    check("t5_busy_pre", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_busy_rst", busy, 0);
    for (int j = 0; j < NCPU; j++) check("t5_out_rst", to_w(j), 0);
    from_w[1] = '0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    do_txn(1, 3'b100, 3'd3);

    // Two simultaneous held requests: round-robin order, no double service
    do_reset();
    from_w[0] = {3'b001, 3'b100, 3'd1, 4'h0};
    from_w[2] = {3'b001, 3'b100, 3'd6, 4'h0};
    w = -1;
    for (int k = 0; k < NCPU; k++)
      if (w < 0 && (((rr_m + k) % NCPU) == 0 || ((rr_m + k) % NCPU) == 2)) w = (rr_m + k) % NCPU;
    o = (w == 0) ? 2 : 0;
    tick();
    c = 1;
    check("t3_bcast_cpu1", to_w(1), {3'b000, 3'b100, (w == 0) ? 3'd1 : 3'd6, 4'h0});
    check("t3_first_quiet", to_w(w), 0);
    t = to_w(w);
    while (!t[10] && c < 40) begin tick(); c++; t = to_w(w); end
    check("t3_first_lat", c, 6);
    check("t3_first_data", t, {3'b001, 3'b000, (w == 0) ? 3'd1 : 3'd6, (w == 0) ? mem_m[1] : mem_m[6]});
    t = to_w(o);
    while (!t[10] && c < 60) begin tick(); c++; t = to_w(o); end
    check("t3_second_lat", c, 13);
    check("t3_second_data", t, {3'b001, 3'b000, (o == 0) ? 3'd1 : 3'd6, (o == 0) ? mem_m[1] : mem_m[6]});
    hb = 0;
    repeat (20) begin tick(); if (busy) hb++; end
    check("t3_no_reserve", hb, 0);
    from_w[0] = '0;
    from_w[2] = '0;
    tick();

`ifdef BUS_MEM_STATS_EN
    do_reset();
    check("stat_rd_rst", stat_rd, 0);
    do_txn(0, 3'b100, 3'd1);
    do_txn(1, 3'b100, 3'd2);
    rep_on[0] = 1'b1; rep_w[0] = {1'b1, 1'b0, 1'b0, 3'b000, 3'd7, 4'h9}; rep_cyc[0] = 3;
    do_txn(2, 3'b010, 3'd7);
    check("stat_rd", stat_rd, 2);
    check("stat_wr", stat_wr, 1);
    check("stat_inv", stat_inv, 0);
    check("stat_wb", stat_wb, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
